// File: rtl/iomem_sevenseg_pkg.sv
// ============================================================================
// Module      : iomem_sevenseg_pkg
// Description : Register offsets and CTRL field layout for iomem_sevenseg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package iomem_sevenseg_pkg;

    // Offsets are word indexes, i.e. iomem_addr[7:2].
    localparam logic [5:0] SEVENSEG_DATA = 6'h00;
    localparam logic [5:0] SEVENSEG_CTRL = 6'h01;
    localparam logic [5:0] SEVENSEG_STAT = 6'h02;

    localparam int c_CTRL_EN_BIT   = 0;
    localparam int c_CTRL_DP_LSB   = 4;
    localparam int c_CTRL_BLANK_LSB = 8;

    typedef struct packed {
        logic [3:0] blank;
        logic [3:0] dp;
        logic       en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[c_CTRL_EN_BIT]                    = c.en;
        w[c_CTRL_DP_LSB +: 4]               = c.dp;
        w[c_CTRL_BLANK_LSB +: 4]            = c.blank;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sevenseg_hex_decode.sv
// ============================================================================
// Module      : sevenseg_hex_decode
// Description : Hex nibble to active-low a..g segment pattern (seg[0] = a).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sevenseg_hex_decode (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/iomem_sevenseg.sv
// ============================================================================
// Module      : iomem_sevenseg
// Description : iomem-mapped 4-digit common-anode 7-segment display controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iomem_sevenseg
    import iomem_sevenseg_pkg::*;
#(
    parameter logic [7:0] ADDR_HI  = 8'h04,
    parameter int         SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int              c_PW       = $clog2(SCAN_DIV);
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(SCAN_DIV - 1);

    logic            r_ready;
    logic [31:0]     r_rdata;
    logic [15:0]     r_data;
    ctrl_t           r_ctrl;
    logic [c_PW-1:0] r_pre;
    logic [1:0]      r_digit;
    logic [6:0]      r_seg;
    logic            r_dp;
    logic [3:0]      r_an;

    logic            w_hit;
    logic [5:0]      w_off;
    logic [31:0]     w_rd;
    logic [3:0]      w_nibble;
    logic [6:0]      w_font;
    logic            w_dark;
    logic            w_unused;

    assign w_hit = iomem_valid && !r_ready && (iomem_addr[31:24] == ADDR_HI);
    assign w_off = iomem_addr[7:2];

    assign w_unused = ^{iomem_addr[23:8], iomem_addr[1:0], iomem_wdata[31:16],
                        iomem_wdata[3:1], iomem_wstrb[3:2]};

    always_comb begin
        w_rd = '0;
        case (w_off)
            SEVENSEG_DATA: w_rd = {16'h0000, r_data};
            SEVENSEG_CTRL: w_rd = ctrl_to_word(r_ctrl);
            SEVENSEG_STAT: w_rd = {30'h0, r_digit};
            default:       w_rd = '0;
        endcase
    end

    // Bus and register block: rdata captures the pre-write register value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else begin
            r_ready <= w_hit;
            r_rdata <= w_hit ? w_rd : 32'h0;
            if (w_hit && (w_off == SEVENSEG_DATA)) begin
                if (iomem_wstrb[0]) r_data[7:0]  <= iomem_wdata[7:0];
                if (iomem_wstrb[1]) r_data[15:8] <= iomem_wdata[15:8];
            end
            if (w_hit && (w_off == SEVENSEG_CTRL)) begin
                if (iomem_wstrb[0]) begin
                    r_ctrl.en <= iomem_wdata[c_CTRL_EN_BIT];
                    r_ctrl.dp <= iomem_wdata[c_CTRL_DP_LSB +: 4];
                end
                if (iomem_wstrb[1]) r_ctrl.blank <= iomem_wdata[c_CTRL_BLANK_LSB +: 4];
            end
        end
    end

    // Scan uses the enable held before this edge, so a CTRL write takes effect next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre   <= '0;
            r_digit <= '0;
        end else if (!r_ctrl.en) begin
            r_pre   <= '0;
            r_digit <= '0;
        end else if (r_pre == c_PRE_LAST) begin
            r_pre   <= '0;
            r_digit <= r_digit + 2'd1;
        end else begin
            r_pre   <= r_pre + 1'b1;
        end
    end

    assign w_nibble = r_data[{r_digit, 2'b00} +: 4];
    assign w_dark   = !r_ctrl.en || r_ctrl.blank[r_digit];

    sevenseg_hex_decode u_hex_decode (
        .nibble (w_nibble),
        .seg    (w_font)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= 4'hF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else if (w_dark) begin
            r_an  <= 4'hF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~(4'b0001 << r_digit);
            r_seg <= w_font;
            r_dp  <= ~r_ctrl.dp[r_digit];
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign an          = r_an;

endmodule

`default_nettype wire

// File: tb/tb_iomem_sevenseg.sv
// ============================================================================
// Module      : tb_iomem_sevenseg
// Description : Directed self-checking bench for iomem_sevenseg (SCAN_DIV = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iomem_sevenseg;

    localparam logic [7:0] c_HI = 8'h04;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    iomem_sevenseg #(.ADDR_HI(c_HI), .SCAN_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .seg         (seg),
        .dp          (dp),
        .an          (an)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following the ack.
    task automatic bus(input logic [7:0] off, input logic [3:0] strb,
                       input logic [31:0] wd, output logic [31:0] r);
        bit acked;
        acked = 1'b0;
        iomem_valid = 1'b1;
        iomem_addr  = {c_HI, 16'h5A5A, off};
        iomem_wstrb = strb;
        iomem_wdata = wd;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk);
            #1;
            if (iomem_ready) acked = 1'b1;
        end
        check("ack", {31'h0, acked}, 32'h1);
        r = iomem_rdata;
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    // 16 cycles of outputs; slot k expectations sit in the k-th field.
    task automatic scan_check(input string tag, input logic [15:0] an_e,
                              input logic [27:0] seg_e, input logic [3:0] dp_e);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_an"},  {28'h0, an},  {28'h0, an_e[(i/4)*4 +: 4]});
            check({tag, "_seg"}, {25'h0, seg}, {25'h0, seg_e[(i/4)*7 +: 7]});
            check({tag, "_dp"},  {31'h0, dp},  {31'h0, dp_e[i/4]});
        end
    endtask

    initial begin
        // 1. reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an",    {28'h0, an},  32'hF);
        check("rst_seg",   {25'h0, seg}, 32'h7F);
        check("rst_dp",    {31'h0, dp},  32'h1);
        check("rst_ready", {31'h0, iomem_ready}, 32'h0);
        check("rst_rdata", iomem_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        bus(8'h00, 4'h0, 32'h0, rd);
        check("rd_data0", rd, 32'h0);
        @(posedge clk);
        #1;
        check("ready_pulse", {31'h0, iomem_ready}, 32'h0);
        @(negedge clk);

        // 2. plain scan
        bus(8'h00, 4'hF, 32'h0000_12AF, rd);
        bus(8'h04, 4'hF, 32'h0000_0001, rd);
        scan_check("scan1", {4'h7, 4'hB, 4'hD, 4'hE},
                   {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111);

        // 3. blank + dp masks, STAT walk
        @(negedge clk);
        bus(8'h04, 4'hF, 32'h0, rd);
        bus(8'h04, 4'h3, 32'h0000_0231, rd);
        for (int k = 0; k < 8; k++) begin
            bus(8'h08, 4'h0, 32'h0, rd);
            check("stat", rd, 32'(k / 2));
        end
        bus(8'h04, 4'hF, 32'h0, rd);
        bus(8'h04, 4'h3, 32'h0000_0231, rd);
        scan_check("scan2", {4'h7, 4'hB, 4'hF, 4'hE},
                   {7'h79, 7'h24, 7'h7F, 7'h0E}, 4'b1110);

        // 4. byte lanes, unmapped offset, CTRL reserved bits
        @(negedge clk);
        bus(8'h00, 4'b0001, 32'hFFFF_FF88, rd);
        check("wr_old_data", rd, 32'h0000_12AF);
        bus(8'h00, 4'h0, 32'h0, rd);
        check("rd_data_lane", rd, 32'h0000_1288);
        bus(8'h10, 4'hF, 32'hFFFF_FFFF, rd);
        check("wr_unmapped", rd, 32'h0);
        bus(8'h10, 4'h0, 32'h0, rd);
        check("rd_unmapped", rd, 32'h0);
        bus(8'h08, 4'hF, 32'hFFFF_FFFF, rd);
        bus(8'h00, 4'h0, 32'h0, rd);
        check("rd_data_keep", rd, 32'h0000_1288);
        bus(8'h04, 4'h0, 32'h0, rd);
        check("rd_ctrl", rd, 32'h0000_0231);
        bus(8'h04, 4'hF, 32'hFFFF_FFFF, rd);
        check("wr_ctrl_old", rd, 32'h0000_0231);
        bus(8'h04, 4'h0, 32'h0, rd);
        check("rd_ctrl_ff", rd, 32'h0000_0FF1);
        bus(8'h04, 4'hF, 32'h0, rd);

        // 5. held valid and foreign window
        @(posedge clk);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = {c_HI, 24'h0};
        iomem_wstrb = 4'h0;
        #1;
        check("hold_rdy0", {31'h0, iomem_ready}, 32'h0);
        for (int i = 1; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("hold_rdy", {31'h0, iomem_ready}, 32'(i % 2));
        end
        @(negedge clk);
        iomem_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("foreign_rdy", {31'h0, iomem_ready}, 32'h0);
        end
        @(negedge clk);
        iomem_valid = 1'b0;

        // 6. async reset mid-transfer and mid-scan
        bus(8'h04, 4'hF, 32'h0000_0001, rd);
        repeat (5) @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = {c_HI, 24'h0};
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h0000_BEEF;
        @(posedge clk);
        #1;
        check("pre_rst_ready", {31'h0, iomem_ready}, 32'h1);
        check("pre_rst_lit", {31'h0, (an == 4'hF)}, 32'h0);
        reset = 1'b1;
        #1;
        check("arst_ready", {31'h0, iomem_ready}, 32'h0);
        check("arst_an",    {28'h0, an},  32'hF);
        check("arst_seg",   {25'h0, seg}, 32'h7F);
        check("arst_rdata", iomem_rdata, 32'h0);
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        reset = 1'b0;
        @(negedge clk);
        bus(8'h04, 4'h0, 32'h0, rd);
        check("post_ctrl", rd, 32'h0);
        bus(8'h00, 4'h0, 32'h0, rd);
        check("post_data", rd, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_dark", {28'h0, an}, 32'hF);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
